// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Purpose : Program counter and fetch sequencer with start/done handshake.
//           Optional one-deep call/return link register under `PC_LINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int D    = 12,
    parameter int OFFW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abs_jump,
    input  logic [D-1:0]    target,
    input  logic            rel_jump,
    input  logic [OFFW-1:0] offset,
    input  logic            stall,
    input  logic            halt,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [D-1:0]    prog_ctr,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [D-1:0]   pc_q;
    logic [D-1:0]   pc_d;
    logic           busy_q;
    logic           done_q;
    logic [D-1:0]   w_off_sext;
    logic [D-1:0]   w_pc_inc;

    // Both sums wrap silently modulo 2^D.
    assign w_off_sext = D'($signed(offset));
    assign w_pc_inc   = pc_q + D'(1);

`ifdef PC_LINK_EN
    logic [D-1:0]   link_q;

    always_comb begin
        pc_d = w_pc_inc;
        if (ret_en)        pc_d = link_q;
        else if (abs_jump) pc_d = target;
        else if (rel_jump) pc_d = pc_q + w_off_sext;
        else if (stall)    pc_d = pc_q;
    end
`else
    logic w_unused_link;
    assign w_unused_link = &{1'b0, call_en, ret_en};

    always_comb begin
        pc_d = w_pc_inc;
        if (abs_jump)      pc_d = target;
        else if (rel_jump) pc_d = pc_q + w_off_sext;
        else if (stall)    pc_d = pc_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PC_LINK_EN
            link_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
`ifdef PC_LINK_EN
                        // Return address captured on the same edge as the call jump.
                        if (!ret_en && abs_jump && call_en)
                            link_q <= w_pc_inc;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Scoreboard bench for pc_sequencer: directed cases plus random run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int D    = 12;
    localparam int OFFW = 8;
    localparam int MODV = 1 << D;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abs_jump = 1'b0;
    logic [D-1:0]    target = '0;
    logic            rel_jump = 1'b0;
    logic [OFFW-1:0] offset = '0;
    logic            stall = 1'b0;
    logic            halt = 1'b0;
    logic            call_en = 1'b0;
    logic            ret_en = 1'b0;
    logic [D-1:0]    prog_ctr;
    logic            busy;
    logic            done;

    pc_sequencer #(.D(D), .OFFW(OFFW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abs_jump (abs_jump),
        .target   (target),
        .rel_jump (rel_jump),
        .offset   (offset),
        .stall    (stall),
        .halt     (halt),
        .call_en  (call_en),
        .ret_en   (ret_en),
        .prog_ctr (prog_ctr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    pc;
        bit    busy;
        bit    done;
        string name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished.
    int   m_mode = 0;
    int   m_pc   = 0;
    int   m_link = 0;
`ifdef PC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    task automatic model_update();
        if (reset) begin
            m_mode = 0; m_pc = 0; m_link = 0;
        end else if (m_mode == 1) begin
            if (halt) m_mode = 2;
            else if (LINK && ret_en) m_pc = m_link;
            else if (abs_jump) begin
                if (LINK && call_en) m_link = (m_pc + 1) % MODV;
                m_pc = int'(target);
            end else if (rel_jump)
                m_pc = (((m_pc + int'($signed(offset))) % MODV) + MODV) % MODV;
            else if (!stall) m_pc = (m_pc + 1) % MODV;
        end else if (start) begin
            m_mode = 1; m_pc = 0;
        end
    endtask

    // Drive one cycle of inputs; use_exp selects a hand-written expectation
    // instead of the model's prediction.
    task automatic step(input bit r, input bit st, input bit aj, input int tgt,
                        input bit rj, input int off, input bit sl, input bit hl,
                        input bit ce, input bit re, input string nm,
                        input bit use_exp, input int epc, input bit eb, input bit ed);
        exp_t e;
        @(negedge clk);
        reset = r; start = st; abs_jump = aj; target = D'(tgt);
        rel_jump = rj; offset = OFFW'(off); stall = sl; halt = hl;
        call_en = ce; ret_en = re;
        model_update();
        e.name = nm;
        if (use_exp) begin
            e.pc = epc; e.busy = eb; e.done = ed;
        end else begin
            e.pc = m_pc; e.busy = (m_mode == 1); e.done = (m_mode == 2);
        end
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input int epc, input bit eb, input bit ed);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm, 1, epc, eb, ed);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (prog_ctr !== D'(e.pc) || busy !== e.busy || done !== e.done) begin
                bad++;
                $display("FAIL %s: got pc=%0d busy=%0b done=%0b, want pc=%0d busy=%0b done=%0b",
                         e.name, prog_ctr, busy, done, e.pc, e.busy, e.done);
            end
        end
    end

    initial begin
        int wait_cyc;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset", 1, 0, 0, 0);
        step(0, 0, 1, 55, 1, 3, 0, 1, 1, 1, "idle_ignores", 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "start", 1, 0, 1, 0);
        for (int i = 1; i <= 5; i++) idle("count", i, 1, 0);
        step(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, "abs_jump", 1, 2, 1, 0);
        step(0, 0, 0, 0, 1, -2, 0, 0, 0, 0, "rel_neg", 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, "rel_pos", 1, 3, 1, 0);
        step(0, 0, 1, 20, 0, 0, 0, 0, 1, 0, "call", 1, 20, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "ret", 1, LINK ? 4 : 21, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "start_in_run", 1, LINK ? 5 : 22, 1, 0);
        step(0, 0, 1, 4095, 0, 0, 0, 0, 0, 0, "jump_top", 1, 4095, 1, 0);
        idle("wrap_up", 0, 1, 0);
        step(0, 0, 0, 0, 1, -1, 0, 0, 0, 0, "wrap_down", 1, 4095, 1, 0);
        step(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, "jump7", 1, 7, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "stall", 1, 7, 1, 0);
        step(0, 0, 0, 0, 1, 9, 1, 0, 0, 0, "rel_over_stall", 1, 16, 1, 0);
        step(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, "jump7b", 1, 7, 1, 0);
        step(1, 1, 1, 9, 0, 0, 0, 1, 0, 0, "reset_mid_run", 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "restart", 1, 0, 1, 0);
        for (int i = 1; i <= 9; i++) idle("count9", i, 1, 0);
        step(0, 0, 1, 100, 0, 0, 1, 1, 0, 0, "halt_prio", 1, 9, 0, 1);
        step(0, 0, 1, 50, 1, 5, 0, 0, 0, 0, "done_hold", 1, 9, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "start_from_done", 1, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(4) == 0), int'($urandom_range(MODV - 1)),
                 ($urandom_range(4) == 0), int'($urandom_range(255)),
                 ($urandom_range(4) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(2) == 0), ($urandom_range(7) == 0),
                 "random", 0, 0, 0, 0);
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
